int_dot_accum: RTL and testbench

//  Sequential signed-integer dot-product engine for one neuron: accumulates
//  N_TERMS products of unsigned pixel x signed weight onto a signed bias.

---
 rtl/int_dot_accum.sv | 120 ++++++++++++
 tb/tb_int_dot_accum.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/int_dot_accum.sv
// Sequential dot-product engine: bias + sum(pixel * weight) over N_TERMS beats.
// Optional ACC_SAT_EN macro: saturating accumulator with sticky ovf; otherwise wraps.
module int_dot_accum #(
  parameter int N_TERMS = 784,
  parameter int PIX_W   = 8,
  parameter int WGT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             bias,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [PIX_W-1:0]        pixel,
  input  logic signed [WGT_W-1:0] weight,
  output logic [31:0]             acc_out,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic                    busy,
  output logic                    ovf
);

  // state | meaning
  // IDLE  | waiting for start; beats ignored
  // ACCUM | accepting beats, one product per fired beat
  // HOLD  | result presented on acc_out until out_rdy

  localparam int          PROD_W = PIX_W + WGT_W + 1;
  localparam logic [15:0] LAST   = 16'(N_TERMS - 1);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t                    state, state_nxt;
  logic [31:0]               acc, acc_nxt;
  logic [15:0]               cnt, cnt_nxt;
  logic                      fire;
  logic signed [PROD_W-1:0]  pix_ext, wgt_ext, prod;
  logic [31:0]               acc_sum;

  // Pixel is unsigned, so it gets a zero sign bit before the signed multiply.
  assign pix_ext = PROD_W'({1'b0, pixel});
  assign wgt_ext = PROD_W'(weight);
  assign prod    = pix_ext * wgt_ext;

`ifdef ACC_SAT_EN
  logic [32:0] sum_wide;
  logic        sum_ovf;
  logic        ovf_r, ovf_nxt;

  assign sum_wide = {acc[31], acc} + 33'(prod);
  assign sum_ovf  = sum_wide[32] ^ sum_wide[31];
  assign acc_sum  = !sum_ovf     ? sum_wide[31:0] :
                    sum_wide[32] ? 32'h8000_0000  : 32'h7FFF_FFFF;
  assign ovf      = ovf_r;
`else
  assign acc_sum  = acc + 32'(prod);
  assign ovf      = 1'b0;
`endif

  assign fire    = in_vld && (state == ACCUM);
  assign in_rdy  = (state == ACCUM);
  assign out_vld = (state == HOLD);
  assign busy    = (state != IDLE);
  assign acc_out = acc;

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cnt_nxt   = cnt;
`ifdef ACC_SAT_EN
    ovf_nxt   = ovf_r;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          acc_nxt   = bias;
          cnt_nxt   = 16'd0;
`ifdef ACC_SAT_EN
          ovf_nxt   = 1'b0;
`endif
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (fire) begin
          acc_nxt = acc_sum;
          cnt_nxt = cnt + 16'd1;
`ifdef ACC_SAT_EN
          ovf_nxt = ovf_r | sum_ovf;
`endif
          if (cnt == LAST) state_nxt = HOLD;
        end
      end
      HOLD: begin
        // start arriving alongside out_rdy is deliberately dropped
        if (out_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= 32'd0;
      cnt   <= 16'd0;
`ifdef ACC_SAT_EN
      ovf_r <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      cnt   <= cnt_nxt;
`ifdef ACC_SAT_EN
      ovf_r <= ovf_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_int_dot_accum.sv
// Bench for int_dot_accum: three instances (N_TERMS = 4, 1, 784) against a
// longint reference model; honours ACC_SAT_EN when defined.
module tb_int_dot_accum;

  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic               clk = 1'b0;
  logic               rst;
  logic [2:0]         start_v;
  logic [31:0]        bias;
  logic               in_vld;
  logic [7:0]         pixel;
  logic signed [15:0] weight;
  logic               out_rdy;

  logic [31:0] acc_o [3];
  logic [2:0]  vld_o, rdy_o, busy_o, ovf_o;

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  int pq [784];
  int wq [784];

  always #5 clk = ~clk;

  int_dot_accum #(.N_TERMS(4)) u_n4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .bias(bias), .in_vld(in_vld),
    .in_rdy(rdy_o[0]), .pixel(pixel), .weight(weight), .acc_out(acc_o[0]),
    .out_vld(vld_o[0]), .out_rdy(out_rdy), .busy(busy_o[0]), .ovf(ovf_o[0]));

  int_dot_accum #(.N_TERMS(1)) u_n1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .bias(bias), .in_vld(in_vld),
    .in_rdy(rdy_o[1]), .pixel(pixel), .weight(weight), .acc_out(acc_o[1]),
    .out_vld(vld_o[1]), .out_rdy(out_rdy), .busy(busy_o[1]), .ovf(ovf_o[1]));

  int_dot_accum #(.N_TERMS(784)) u_n784 (
    .clk(clk), .rst(rst), .start(start_v[2]), .bias(bias), .in_vld(in_vld),
    .in_rdy(rdy_o[2]), .pixel(pixel), .weight(weight), .acc_out(acc_o[2]),
    .out_vld(vld_o[2]), .out_rdy(out_rdy), .busy(busy_o[2]), .ovf(ovf_o[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Exact signed sum; saturate per step or wrap mod 2^32 at the end.
  task automatic model(input int n, input logic [31:0] b,
                       output logic [31:0] res, output logic ov);
    longint a;
    a  = longint'($signed(b));
    ov = 1'b0;
    for (int i = 0; i < n; i++) begin
      a = a + longint'(pq[i]) * longint'(wq[i]);
`ifdef ACC_SAT_EN
      if (a > MAXV) begin a = MAXV; ov = 1'b1; end
      else if (a < MINV) begin a = MINV; ov = 1'b1; end
`endif
    end
    res = a[31:0];
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input int s, input string tag);
    chk({tag, "_acc"},  acc_o[s], 32'd0);
    chk({tag, "_vld"},  32'(vld_o[s]), 32'd0);
    chk({tag, "_rdy"},  32'(rdy_o[s]), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o[s]), 32'd0);
    chk({tag, "_ovf"},  32'(ovf_o[s]), 32'd0);
  endtask

  task automatic run_neuron(input int s, input int n, input logic [31:0] b,
                            input bit stall, input int hold_cyc, input bit poke,
                            input string tag);
    logic [31:0] exp_acc;
    logic        exp_ov;
    model(n, b, exp_acc, exp_ov);
    sel        = s;
    start_v[s] = 1'b1;
    bias       = b;
    tick();
    start_v[s] = 1'b0;
    bias       = ~b;
    chk({tag, "_busy_start"}, 32'(busy_o[s]), 32'd1);
    chk({tag, "_rdy_start"},  32'(rdy_o[s]), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (stall && (i % 2 == 0)) begin
        in_vld = 1'b0;
        pixel  = 8'($urandom);
        weight = 16'($urandom);
        tick();
      end
      in_vld = 1'b1;
      pixel  = 8'(pq[i]);
      weight = 16'(wq[i]);
      if (poke && i == 1) start_v[s] = 1'b1;
      if (i == n - 1) begin
        chk({tag, "_vld_pre"}, 32'(vld_o[s]), 32'd0);
        chk({tag, "_rdy_pre"}, 32'(rdy_o[s]), 32'd1);
      end
      tick();
      start_v[s] = 1'b0;
    end
    in_vld = 1'b0;
    chk({tag, "_vld"},  32'(vld_o[s]), 32'd1);
    chk({tag, "_acc"},  acc_o[s], exp_acc);
    chk({tag, "_ovf"},  32'(ovf_o[s]), 32'(exp_ov));
    chk({tag, "_rdy_hold"},  32'(rdy_o[s]), 32'd0);
    chk({tag, "_busy_hold"}, 32'(busy_o[s]), 32'd1);
    for (int h = 0; h < hold_cyc; h++) begin
      if (poke) start_v[s] = 1'b1;
      tick();
      chk({tag, "_hold_vld"}, 32'(vld_o[s]), 32'd1);
      chk({tag, "_hold_acc"}, acc_o[s], exp_acc);
    end
    out_rdy = 1'b1;
    if (poke) start_v[s] = 1'b1;
    tick();
    out_rdy    = 1'b0;
    start_v[s] = 1'b0;
    chk({tag, "_vld_done"},  32'(vld_o[s]), 32'd0);
    chk({tag, "_busy_done"}, 32'(busy_o[s]), 32'd0);
    tick();
    chk({tag, "_idle_stay"}, 32'(busy_o[s]), 32'd0);
  endtask

  task automatic load_t1();
    pq[0] = 1; pq[1] = 2;  pq[2] = 3; pq[3] = 4;
    wq[0] = 5; wq[1] = -6; wq[2] = 7; wq[3] = -8;
  endtask

  initial begin
    rst     = 1'b1;
    start_v = 3'b000;
    bias    = 32'd0;
    in_vld  = 1'b0;
    pixel   = 8'd0;
    weight  = 16'sd0;
    out_rdy = 1'b0;
    tick();
    tick();
    for (int s = 0; s < 3; s++) chk_reset(s, "reset");
    rst = 1'b0;
    tick();

    load_t1();
    run_neuron(0, 4, 32'd10, 1'b0, 0, 1'b0, "t1");
    run_neuron(0, 4, 32'd10, 1'b1, 3, 1'b0, "t2");
    run_neuron(0, 4, 32'd10, 1'b0, 2, 1'b1, "t4");

    // Reset in the middle of a neuron after two beats.
    sel        = 0;
    start_v[0] = 1'b1;
    bias       = 32'd10;
    tick();
    start_v[0] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_vld = 1'b1;
      pixel  = 8'(pq[i]);
      weight = 16'(wq[i]);
      tick();
    end
    in_vld = 1'b0;
    rst    = 1'b1;
    tick();
    chk_reset(0, "t5_rst");
    rst = 1'b0;
    tick();
    chk_reset(0, "t5_after");
    run_neuron(0, 4, 32'd10, 1'b0, 0, 1'b0, "t5_fresh");

    pq[0] = 0;
    wq[0] = -32768;
    run_neuron(1, 1, 32'hFFFF_FFFF, 1'b0, 1, 1'b0, "t6");

    for (int i = 0; i < 784; i++) begin
      pq[i] = 255;
      wq[i] = 32767;
    end
    run_neuron(2, 784, 32'h7FFF_0000, 1'b0, 1, 1'b0, "t3");

    for (int r = 0; r < 8; r++) begin
      logic [31:0] b;
      for (int i = 0; i < 4; i++) begin
        pq[i] = int'($urandom_range(0, 255));
        wq[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      case (r % 3)
        0:       b = 32'h7FFF_F000 + 32'($urandom_range(0, 4095));
        1:       b = 32'h8000_0000 + 32'($urandom_range(0, 4095));
        default: b = $urandom;
      endcase
      run_neuron(0, 4, b, 1'($urandom_range(0, 1)), $urandom_range(0, 2),
                 1'($urandom_range(0, 1)), "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
